// File: rtl/dr_pkg.sv
// Shared dual-rail encoding, handshake state type and codec helpers for the
// dual-rail adder driver.
package dr_pkg;

  localparam logic [1:0] DR_NULL    = 2'b00;
  localparam logic [1:0] DR_ONE     = 2'b01;
  localparam logic [1:0] DR_ZERO    = 2'b10;
  localparam logic [1:0] DR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    NULL,
    DONE
  } dr_state_e;

  function automatic logic [1:0] dr_encode(input logic b);
    return b ? DR_ONE : DR_ZERO;
  endfunction

  function automatic logic dr_decode(input logic [1:0] pair);
    return pair == DR_ONE;
  endfunction

endpackage

// File: rtl/dr_sync.sv
// Multi-flop synchronizer bringing self-timed dual-rail outputs into the clk
// domain; every flop resets to zero, which reads as all-NULL.
module dr_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // NOTE: the flop array is reset explicitly, element by element; an unreset
  // stage could present a stale "complete" code right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign data_o = stage_q[STAGES-1];

endmodule

// File: rtl/dr_adder_driver.sv
// Clocked four-phase initiator for the dual-rail adder: encodes operands, waits
// for completion and emptiness, decodes sum/carry. Per-phase timeout: DR_TIMEOUT_EN.
module dr_adder_driver
  import dr_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
`ifdef DR_TIMEOUT_EN
  , parameter int TIMEOUT   = 255
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DIGITS-1:0]   op_a,
  input  logic [DIGITS-1:0]   op_b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [DIGITS-1:0]   sum,
  output logic                cout,
  output logic                error,
  output logic [2*DIGITS-1:0] dr_a,
  output logic [2*DIGITS-1:0] dr_b,
  output logic [1:0]          dr_cin,
  input  logic [2*DIGITS-1:0] dr_s,
  input  logic [1:0]          dr_cout
);

  localparam int PAIRS = DIGITS + 1;

  dr_state_e           state_q;
  logic [2*DIGITS-1:0] dr_a_q, dr_b_q;
  logic [1:0]          dr_cin_q;
  logic                busy_q, done_q, cout_q, error_q;
  logic [DIGITS-1:0]   sum_q;

  logic [2*PAIRS-1:0]  rsp_sync;

  dr_sync #(
    .WIDTH  (2*PAIRS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i ({dr_cout, dr_s}),
    .data_o (rsp_sync)
  );

  logic                rsp_complete, rsp_empty, rsp_illegal;
  logic [DIGITS-1:0]   sum_d;
  logic                cout_d;
  logic [2*DIGITS-1:0] dr_a_d, dr_b_d;

  // NOTE: every always_comb output gets a default before the loops so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    rsp_complete = 1'b1;
    rsp_empty    = 1'b1;
    rsp_illegal  = 1'b0;
    sum_d        = '0;
    dr_a_d       = '0;
    dr_b_d       = '0;
    for (int i = 0; i < PAIRS; i++) begin
      if (rsp_sync[2*i +: 2] == DR_NULL) rsp_complete = 1'b0;
      else                               rsp_empty    = 1'b0;
      if (rsp_sync[2*i +: 2] == DR_ILLEGAL) rsp_illegal = 1'b1;
    end
    for (int i = 0; i < DIGITS; i++) begin
      sum_d[i]           = dr_decode(rsp_sync[2*i +: 2]);
      dr_a_d[2*i +: 2]   = dr_encode(op_a[i]);
      dr_b_d[2*i +: 2]   = dr_encode(op_b[i]);
    end
    cout_d = dr_decode(rsp_sync[2*DIGITS +: 2]);
  end

  logic timeout;

`ifdef DR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          phase_exit;

  assign timeout    = (cnt_q == CW'(TIMEOUT - 1));
  assign phase_exit = ((state_q == DATA) && (rsp_illegal || rsp_complete || timeout)) ||
                      ((state_q == NULL) && (rsp_empty || timeout));

  // Counts cycles spent in the current DATA or NULL phase; restarts on every exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          cnt_q <= '0;
    else if (phase_exit || !(state_q inside {DATA, NULL})) cnt_q <= '0;
    else                                                 cnt_q <= cnt_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch sees the values from before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dr_a_q   <= '0;
      dr_b_q   <= '0;
      dr_cin_q <= DR_NULL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dr_a_q   <= dr_a_d;
            dr_b_q   <= dr_b_d;
            dr_cin_q <= dr_encode(cin);
            busy_q   <= 1'b1;
            error_q  <= 1'b0;
            state_q  <= DATA;
          end
        end
        DATA: begin
          // An illegal code wins over completion; the result is then discarded.
          if (rsp_illegal || (!rsp_complete && timeout)) begin
            error_q  <= 1'b1;
            dr_a_q   <= '0;
            dr_b_q   <= '0;
            dr_cin_q <= DR_NULL;
            state_q  <= NULL;
          end else if (rsp_complete) begin
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            dr_a_q   <= '0;
            dr_b_q   <= '0;
            dr_cin_q <= DR_NULL;
            state_q  <= NULL;
          end
        end
        NULL: begin
          if (rsp_empty || timeout) begin
            if (!rsp_empty) error_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dr_a   = dr_a_q;
  assign dr_b   = dr_b_q;
  assign dr_cin = dr_cin_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign sum    = sum_q;
  assign cout   = cout_q;
  assign error  = error_q;

endmodule

// File: tb/tb_dr_adder_driver.sv
// Directed bench for dr_adder_driver with a cycle-delayed dual-rail adder model.
module tb_dr_adder_driver;

  localparam int DIGITS  = 4;
  localparam int FWD_DLY = 5;
  localparam int RST_DLY = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [DIGITS-1:0]   op_a = '0;
  logic [DIGITS-1:0]   op_b = '0;
  logic                cin = 1'b0;
  logic                busy, done, cout, error;
  logic [DIGITS-1:0]   sum;
  logic [2*DIGITS-1:0] dr_a, dr_b;
  logic [1:0]          dr_cin;
  logic [2*DIGITS-1:0] dr_s = '0;
  logic [1:0]          dr_cout = '0;

  int errors = 0;
  int checks = 0;

  typedef enum int {M_NORMAL, M_ILLEGAL, M_HANG} mode_e;
  mode_e mode = M_NORMAL;

  always #5 clk = ~clk;

  dr_adder_driver #(
    .DIGITS      (DIGITS),
    .SYNC_STAGES (2)
`ifdef DR_TIMEOUT_EN
    , .TIMEOUT   (8)
`endif
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .error   (error),
    .dr_a    (dr_a),
    .dr_b    (dr_b),
    .dr_cin  (dr_cin),
    .dr_s    (dr_s),
    .dr_cout (dr_cout)
  );

  function automatic logic [1:0] enc(input logic b);
    return b ? 2'b01 : 2'b10;
  endfunction

  // Self-timed adder model: outputs appear FWD_DLY negedges after the inputs
  // become complete and return to NULL RST_DLY negedges after the inputs do.
  int fwd_cnt = 0;
  int rst_cnt = 0;
  always @(negedge clk) begin : adder_model
    logic [2*DIGITS+1:0] in_w;
    logic                in_full, in_null;
    logic [DIGITS:0]     total;
    logic [DIGITS-1:0]   a_m, b_m;
    logic                c_m;
    in_w    = {dr_cin, dr_b, dr_a};
    in_full = 1'b1;
    in_null = 1'b1;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (in_w[2*i +: 2] == 2'b00) in_full = 1'b0;
      else                         in_null = 1'b0;
    end
    for (int i = 0; i < DIGITS; i++) begin
      a_m[i] = (dr_a[2*i +: 2] == 2'b01);
      b_m[i] = (dr_b[2*i +: 2] == 2'b01);
    end
    c_m   = (dr_cin == 2'b01);
    total = {1'b0, a_m} + {1'b0, b_m} + {{DIGITS{1'b0}}, c_m};
    if (in_full) begin
      rst_cnt = 0;
      if (fwd_cnt < FWD_DLY) fwd_cnt++;
      if (fwd_cnt == FWD_DLY && mode != M_HANG) begin
        for (int i = 0; i < DIGITS; i++) dr_s[2*i +: 2] = enc(total[i]);
        dr_cout = enc(total[DIGITS]);
        if (mode == M_ILLEGAL) dr_s[1:0] = 2'b11;
      end
    end else if (in_null) begin
      fwd_cnt = 0;
      if (rst_cnt < RST_DLY) rst_cnt++;
      if (rst_cnt == RST_DLY) begin
        dr_s    = '0;
        dr_cout = '0;
      end
    end
  end

  // Returns at the negedge right after the accepting posedge.
  task automatic start_op(input logic [DIGITS-1:0] a, input logic [DIGITS-1:0] b,
                          input logic c);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // cyc = negedges until done is seen (-1 if never); prev_null = dr_* were all
  // zero on the sample before done.
  task automatic wait_done(output int cyc, output bit prev_null);
    bit pn;
    pn  = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
      pn = (dr_a == '0) && (dr_b == '0) && (dr_cin == 2'b00);
    end
    prev_null = pn;
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (sum !== 4'h0)   begin errors++; $display("FAIL rst_sum got=%h exp=0", sum); end
    checks++; if (cout !== 1'b0)  begin errors++; $display("FAIL rst_cout got=%b exp=0", cout); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error got=%b exp=0", error); end
    checks++;
    if ({dr_a, dr_b, dr_cin} !== 18'h0) begin
      errors++; $display("FAIL rst_dr got=%h exp=0", {dr_a, dr_b, dr_cin});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_add();
    int cyc, extra;
    bit pn;
    start_op(4'h3, 4'h5, 1'b0);
    checks++; if (dr_a !== 8'b10100101) begin errors++; $display("FAIL t1_dr_a got=%b exp=10100101", dr_a); end
    checks++; if (dr_b !== 8'b10011001) begin errors++; $display("FAIL t1_dr_b got=%b exp=10011001", dr_b); end
    checks++; if (dr_cin !== 2'b10)     begin errors++; $display("FAIL t1_dr_cin got=%b exp=10", dr_cin); end
    checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL t1_busy got=%b exp=1", busy); end
    wait_done(cyc, pn);
    checks++; if (cyc != 14)   begin errors++; $display("FAIL t1_latency got=%0d exp=14", cyc); end
    checks++; if (sum !== 4'h8) begin errors++; $display("FAIL t1_sum got=%h exp=8", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL t1_cout got=%b exp=0", cout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_done got=%b exp=0", busy); end
    count_done(5, extra);
    checks++; if (extra != 0)  begin errors++; $display("FAIL t1_extra_done got=%0d exp=0", extra); end
  endtask

  task automatic test_carry_out();
    int cyc;
    bit pn;
    start_op(4'hF, 4'h1, 1'b1);
    checks++; if (dr_cin !== 2'b01) begin errors++; $display("FAIL t2_dr_cin got=%b exp=01", dr_cin); end
    wait_done(cyc, pn);
    checks++; if (cyc < 0)  begin errors++; $display("FAIL t2_done got=timeout exp=pulse"); end
    checks++; if (pn !== 1'b1) begin errors++; $display("FAIL t2_null_before_done got=%b exp=1", pn); end
    checks++;
    if ({dr_a, dr_b, dr_cin} !== 18'h0) begin
      errors++; $display("FAIL t2_dr_at_done got=%h exp=0", {dr_a, dr_b, dr_cin});
    end
    checks++; if (sum !== 4'h1)  begin errors++; $display("FAIL t2_sum got=%h exp=1", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL t2_cout got=%b exp=1", cout); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_illegal_code();
    int cyc, extra;
    bit pn;
    mode = M_ILLEGAL;
    start_op(4'h2, 4'h2, 1'b0);
    wait_done(cyc, pn);
    checks++; if (cyc < 0)        begin errors++; $display("FAIL t3_done got=timeout exp=pulse"); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL t3_error got=%b exp=1", error); end
    checks++; if (sum !== 4'h1)   begin errors++; $display("FAIL t3_sum_kept got=%h exp=1", sum); end
    checks++; if (cout !== 1'b1)  begin errors++; $display("FAIL t3_cout_kept got=%b exp=1", cout); end
    count_done(4, extra);
    checks++; if (extra != 0)     begin errors++; $display("FAIL t3_extra_done got=%0d exp=0", extra); end
    mode = M_NORMAL;
    start_op(4'h1, 4'h1, 1'b0);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL t3_error_clear got=%b exp=0", error); end
    wait_done(cyc, pn);
    checks++; if (sum !== 4'h2)   begin errors++; $display("FAIL t3_sum_next got=%h exp=2", sum); end
    repeat (2) @(negedge clk);
  endtask

  // Start held high: an op completes every 16 cycles (14 busy, done, one idle).
  task automatic test_back_to_back();
    int dn, idle, first, cyc;
    bit pn;
    dn = 0; idle = 0; first = -1;
    @(negedge clk);
    op_a  = 4'h7;
    op_b  = 4'h9;
    cin   = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        if (first < 0) first = k;
      end
      if (!busy) idle++;
    end
    start = 1'b0;
    checks++; if (first != 14) begin errors++; $display("FAIL t4_first_done got=%0d exp=14", first); end
    checks++; if (dn != 2)     begin errors++; $display("FAIL t4_done_count got=%0d exp=2", dn); end
    checks++; if (idle != 4)   begin errors++; $display("FAIL t4_idle_cycles got=%0d exp=4", idle); end
    wait_done(cyc, pn);
    checks++; if (cyc < 0)       begin errors++; $display("FAIL t4_last_done got=timeout exp=pulse"); end
    checks++; if (sum !== 4'h1)  begin errors++; $display("FAIL t4_sum got=%h exp=1", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL t4_cout got=%b exp=1", cout); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    bit pn;
    start_op(4'h6, 4'h6, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t5_busy_pre got=%b exp=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dr_a, dr_b, dr_cin} !== 18'h0) begin
      errors++; $display("FAIL t5_dr_async got=%h exp=0", {dr_a, dr_b, dr_cin});
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy got=%b exp=0", busy); end
    checks++; if (sum !== 4'h0)  begin errors++; $display("FAIL t5_sum got=%h exp=0", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL t5_cout got=%b exp=0", cout); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_op(4'h4, 4'h3, 1'b0);
    wait_done(cyc, pn);
    checks++; if (cyc < 0)        begin errors++; $display("FAIL t5_done got=timeout exp=pulse"); end
    checks++; if (sum !== 4'h7)   begin errors++; $display("FAIL t5_sum_after got=%h exp=7", sum); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL t5_error got=%b exp=0", error); end
    repeat (2) @(negedge clk);
  endtask

`ifdef DR_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    bit pn;
    mode = M_HANG;
    start_op(4'h2, 4'h3, 1'b0);
    repeat (7) @(negedge clk);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL t6_error_early got=%b exp=0", error); end
    @(negedge clk);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL t6_error got=%b exp=1", error); end
    checks++; if (dr_a !== 8'h00) begin errors++; $display("FAIL t6_null_phase got=%b exp=0", dr_a); end
    wait_done(cyc, pn);
    checks++; if (cyc != 1)       begin errors++; $display("FAIL t6_done got=%0d exp=1", cyc); end
    mode = M_NORMAL;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_add();
    test_carry_out();
    test_illegal_code();
    test_back_to_back();
    test_reset_mid_op();
`ifdef DR_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
